// File: rtl/wam_pkg.sv
// ---------------------------------------------------------------------------
// wam_pkg -- definitions shared by the whack-a-mole tube display arbiter.
//   wam_state_e : display state; the encoding is also the external mode code
//   BLANK, HI_O : tube digit codes for an unlit tube and the "O" glyph
//   IDLE_PAT    : attract pattern shown while no round is running
//   BLINK_PAT   : all-blank pattern for the OVER blink-off phase
// ---------------------------------------------------------------------------
package wam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TIME  = 2'd1,
    ST_SCORE = 2'd2,
    ST_OVER  = 2'd3
  } wam_state_e;

  localparam int unsigned HOLD_W = 4;

  localparam logic [3:0]  BLANK     = 4'hA;
  localparam logic [3:0]  HI_O      = 4'hB;
  localparam logic [15:0] IDLE_PAT  = {4{HI_O}};
  localparam logic [15:0] BLINK_PAT = {4{BLANK}};

endpackage

// File: rtl/wam_hold_cnt.sv
// ---------------------------------------------------------------------------
// wam_hold_cnt -- tick-driven hold counter for the score display.
//   clk, rst     : system clock, synchronous active-high reset
//   clr_i        : force the count to zero (highest priority after rst)
//   load_i       : load load_val_i (wins over dec_i)
//   dec_i        : decrement by one; saturates at zero, never wraps
//   load_val_i   : value loaded by load_i
//   cnt_o        : current count
//   zero_o       : count is zero
// ---------------------------------------------------------------------------
module wam_hold_cnt
  import wam_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              dec_i,
  input  logic [HOLD_W-1:0] load_val_i,
  output logic [HOLD_W-1:0] cnt_o,
  output logic              zero_o
);

  logic [HOLD_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                     cnt_d = '0;
    else if (load_i)               cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/wam_dsp_arb.sv
// ---------------------------------------------------------------------------
// wam_dsp_arb -- chooses what the four-tube display shows during a round.
//   clk        : system clock (all logic on posedge)
//   rst        : synchronous active-high reset
//   start      : pulse, begins a round (from IDLE or OVER)
//   over       : level, round has ended
//   tick       : slow-time enable (~2 Hz)
//   score_upd  : pulse, score changed -> show score for HOLD_TICKS ticks
//   score      : three BCD digits, passed straight to the tubes
//   tleft      : two BCD digits of time remaining, passed straight through
//   dig        : registered tube nibbles, [15:12] is the leftmost tube
//   mode       : registered state code (IDLE=0 TIME=1 SCORE=2 OVER=3)
// Build option: define WAM_BLINK_EN to blink the final score in OVER; without
// it the score is shown steadily and no blink flop exists.
// ---------------------------------------------------------------------------
module wam_dsp_arb
  import wam_pkg::*;
#(
  parameter int unsigned HOLD_TICKS = 2  // legal 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        over,
  input  logic        tick,
  input  logic        score_upd,
  input  logic [11:0] score,
  input  logic [7:0]  tleft,
  output logic [15:0] dig,
  output logic [1:0]  mode
);

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS);

  wam_state_e        state_q, state_d;
  logic [15:0]       dig_q, dig_d;
  logic              hold_clr, hold_load, hold_dec;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_zero;
  logic              blink_d;

  wam_hold_cnt u_hold (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (hold_clr),
    .load_i     (hold_load),
    .dec_i      (hold_dec),
    .load_val_i (HOLD_LOAD),
    .cnt_o      (hold_cnt),
    .zero_o     (hold_zero)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    hold_clr  = 1'b0;
    hold_load = 1'b0;
    hold_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_TIME;
      end
      ST_TIME: begin
        if (over) begin
          state_d = ST_OVER;
        end else if (score_upd) begin
          state_d   = ST_SCORE;
          hold_load = 1'b1;
        end
      end
      ST_SCORE: begin
        // over beats a reload, and a reload beats a tick in the same cycle
        if (over) begin
          state_d = ST_OVER;
        end else if (score_upd) begin
          hold_load = 1'b1;
        end else if (tick) begin
          hold_dec = 1'b1;
          // leave on the tick that takes the count from 1 to 0
          if (hold_zero || hold_cnt == HOLD_W'(1)) state_d = ST_TIME;
        end
      end
      ST_OVER: begin
        if (start) begin
          state_d  = ST_TIME;
          hold_clr = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef WAM_BLINK_EN
  logic blink_q;

  // Phase restarts at 0 on entry to OVER so the score is seen first.
  always_comb begin
    blink_d = 1'b0;
    if (state_q == ST_OVER && state_d == ST_OVER)
      blink_d = tick ? ~blink_q : blink_q;
  end

  always_ff @(posedge clk) begin
    if (rst) blink_q <= 1'b0;
    else     blink_q <= blink_d;
  end
`else
  assign blink_d = 1'b0;
`endif

  // The display is decoded from the next state so it lands together with
  // mode: one cycle after the inputs that caused it.
  always_comb begin
    dig_d = IDLE_PAT;
    case (state_d)
      ST_IDLE:  dig_d = IDLE_PAT;
      ST_TIME:  dig_d = {BLANK, BLANK, tleft};
      ST_SCORE: dig_d = {HI_O, score};
      ST_OVER:  dig_d = blink_d ? BLINK_PAT : {HI_O, score};
      default:  dig_d = IDLE_PAT;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dig_q   <= IDLE_PAT;
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
    end
  end

  assign dig  = dig_q;
  assign mode = state_q;

endmodule
